sysid_timer: RTL and testbench

- Parametrised successor to the constant system-ID slave.
- Avalon-MM slave that returns build identity (ID, timestamp, layout word).
- Adds a free-running uptime counter with an atomic 64-bit read via a high-word shadow, a clear/freeze control, a sticky wrap flag and a scratch register.
- Sits on the processor data bus beside the other peripherals; software reads it at boot for identity and later for elapsed-cycle measurement.

---
 rtl/sysid_pkg.sv | 35 +++
 rtl/sysid_uptime_counter.sv | 59 +++++
 rtl/sysid_timer.sv | 108 ++++++++++
 tb/tb_sysid_timer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID / uptime timer slave: register map,
// control/status bit positions and a byte-lane merge helper.
package sysid_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_CONFIG    = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
    localparam logic [2:0] ADDR_COUNT_LO  = 3'd4;
    localparam logic [2:0] ADDR_COUNT_HI  = 3'd5;
    localparam logic [2:0] ADDR_CONTROL   = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    localparam logic [7:0] LAYOUT_VERSION = 8'h02;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_FREEZE = 1;
    localparam int ST_FREEZE   = 0;
    localparam int ST_WRAP     = 1;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  be);
        logic [31:0] merged;
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with synchronous clear, freeze hold and a
// sticky wrap flag; a wrap in the same cycle as a flag clear keeps the flag set.
module sysid_uptime_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             freeze_we,
    input  logic             freeze_d,
    input  logic             wrap_clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             freeze,
    output logic             wrap_flag
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             freeze_q;
    logic             flag_q;

    // Freeze is the registered value, so clear+freeze together lands on 0 and holds.
    always_comb begin
        count_d    = count_q;
        wrap_pulse = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (!freeze_q) begin
            count_d    = count_q + ONE;
            wrap_pulse = &count_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            freeze_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (freeze_we) begin
                freeze_q <= freeze_d;
            end
            if (wrap_pulse) begin
                flag_q <= 1'b1;
            end else if (wrap_clr) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign count     = count_q;
    assign freeze    = freeze_q;
    assign wrap_flag = flag_q;

endmodule

// File: rtl/sysid_timer.sv
// Avalon-MM system-ID slave with uptime counter: identity words, scratch,
// atomic 64-bit counter read through a high-word shadow, control and status.
module sysid_timer
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd1520001003,
    parameter int          UPTIME_WIDTH  = 64,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [UPTIME_WIDTH-1:0] count;
    logic [63:0]             count_ext;
    logic                    wrap_pulse;
    logic                    freeze;
    logic                    wrap_flag;
    logic                    unused_wrap_pulse;

    logic        ctrl_we;
    logic        status_we;
    logic        scratch_we;
    logic [31:0] scratch;
    logic [31:0] shadow;
    logic [31:0] rd_mux;
    logic [31:0] config_word;

    // Control and status bits all sit in byte lane 0.
    assign ctrl_we    = write && (address == ADDR_CONTROL) && byteenable[0];
    assign status_we  = write && (address == ADDR_STATUS)  && byteenable[0];
    assign scratch_we = write && (address == ADDR_SCRATCH);

    sysid_uptime_counter #(
        .WIDTH (UPTIME_WIDTH)
    ) u_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (ctrl_we && writedata[CTRL_CLEAR]),
        .freeze_we  (ctrl_we),
        .freeze_d   (writedata[CTRL_FREEZE]),
        .wrap_clr   (status_we && writedata[ST_WRAP]),
        .count      (count),
        .wrap_pulse (wrap_pulse),
        .freeze     (freeze),
        .wrap_flag  (wrap_flag)
    );

    assign unused_wrap_pulse = wrap_pulse;
    assign count_ext         = 64'(count);
    assign config_word       = {16'h0000, LAYOUT_VERSION, 8'(UPTIME_WIDTH)};

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_CONFIG:    rd_mux = config_word;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_COUNT_LO:  rd_mux = count_ext[31:0];
            ADDR_COUNT_HI:  rd_mux = shadow;
            ADDR_CONTROL:   rd_mux[CTRL_FREEZE] = freeze;
            ADDR_STATUS: begin
                rd_mux[ST_FREEZE] = freeze;
                rd_mux[ST_WRAP]   = wrap_flag;
            end
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= SCRATCH_RESET;
        end else if (scratch_we) begin
            scratch <= merge_lanes(scratch, writedata, byteenable);
        end
    end

    // Shadow takes the high half of the very count value returned by the low read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (read && (address == ADDR_COUNT_LO)) begin
            shadow <= count_ext[63:32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_sysid_timer.sv
// Directed bench for sysid_timer: a 40-bit instance with non-default identity
// and scratch reset, plus a default instance sharing the same bus stimulus.
module tb_sysid_timer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rd40;
    logic        rdv40;
    logic [31:0] rd64;
    logic        rdv64;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sysid_timer #(
        .ID_VALUE      (32'h5157_0040),
        .TIMESTAMP     (32'd1520001003),
        .UPTIME_WIDTH  (40),
        .SCRATCH_RESET (32'h5A5A_0000)
    ) dut40 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (rd40),
        .readdatavalid (rdv40)
    );

    sysid_timer dut64 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (rd64),
        .readdatavalid (rdv64)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        read       = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0;
        byteenable = 4'h0;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        read    = 1'b1;
        step();
        read    = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        step();
        write      = 1'b0;
        byteenable = 4'h0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (3) @(negedge clock);
        check("rst_rdata", rd40, 32'h0);
        check("rst_valid", 32'(rdv40), 32'd0);
        check("rst_valid64", 32'(rdv64), 32'd0);
        reset_n = 1'b1;

        // identity words, one-cycle valid pulse
        rd(3'd0);
        check("id_valid", 32'(rdv64), 32'd1);
        check("id_default", rd64, 32'h0000_0000);
        check("id_param", rd40, 32'h5157_0040);
        step();
        check("id_pulse_end", 32'(rdv64), 32'd0);
        rd(3'd1);
        check("ts_valid", 32'(rdv64), 32'd1);
        check("timestamp", rd64, 32'd1520001003);
        rd(3'd2);
        check("config64", rd64, 32'h0000_0240);
        check("config40", rd40, 32'h0000_0228);

        // scratch byte lanes, then back-to-back reads
        wr(3'd3, 32'hDEAD_BEEF, 4'b0101);
        check("wr_no_valid", 32'(rdv64), 32'd0);
        address = 3'd3;
        read    = 1'b1;
        step();
        check("b2b_valid0", 32'(rdv64), 32'd1);
        check("scratch64", rd64, 32'h00AD_00EF);
        check("scratch40", rd40, 32'h5AAD_00EF);
        address = 3'd0;
        step();
        check("b2b_valid1", 32'(rdv64), 32'd1);
        check("b2b_id", rd40, 32'h5157_0040);
        read = 1'b0;
        step();
        check("idle_valid", 32'(rdv40), 32'd0);
        check("idle_hold", rd40, 32'h5157_0040);

        // read and write of the same address: pre-write value returned
        address    = 3'd3;
        writedata  = 32'h1234_5678;
        byteenable = 4'hF;
        read       = 1'b1;
        write      = 1'b1;
        step();
        idle();
        check("rw_prewrite", rd64, 32'h00AD_00EF);
        rd(3'd3);
        check("rw_postwrite", rd64, 32'h1234_5678);

        // byteenable=0 control write: no clear, no freeze
        wr(3'd6, 32'h3, 4'h0);
        rd(3'd6);
        check("be0_control", rd40, 32'h0);
        rd(3'd7);
        check("be0_status", rd40, 32'h0);

        // wrap of the 40-bit counter and atomic high-word shadow
        dut40.u_counter.count_q = 40'hFF_FFFF_FFFE;
        address = 3'd4;
        read    = 1'b1;
        step();
        check("cnt_lo", rd40, 32'hFFFF_FFFE);
        address = 3'd5;
        step();
        check("cnt_hi_shadow", rd40, 32'h0000_00FF);
        address = 3'd4;
        step();
        check("cnt_after_wrap", rd40, 32'h0);
        address = 3'd7;
        step();
        check("status_wrap", rd40, 32'h2);
        address = 3'd2;
        step();
        check("config_width", 32'(rd40[7:0]), 32'd40);
        read = 1'b0;

        // wrap and W1C on the same edge: set wins; second W1C clears
        dut40.u_counter.count_q = 40'hFF_FFFF_FFFF;
        wr(3'd7, 32'h2, 4'h1);
        rd(3'd7);
        check("w1c_race", rd40, 32'h2);
        wr(3'd7, 32'h2, 4'h1);
        rd(3'd7);
        check("w1c_clear", rd40, 32'h0);

        // clear on the wrapping edge: counter 0, flag stays clear
        dut40.u_counter.count_q = 40'hFF_FFFF_FFFF;
        wr(3'd6, 32'h1, 4'h1);
        rd(3'd4);
        check("clr_wrap_cnt", rd40, 32'h0);
        rd(3'd7);
        check("clr_wrap_flag", rd40, 32'h0);

        // clear and freeze together: counter parked at 0
        wr(3'd6, 32'h3, 4'h1);
        repeat (5) step();
        rd(3'd4);
        check("frz_cnt_lo", rd40, 32'h0);
        rd(3'd5);
        check("frz_cnt_hi", rd40, 32'h0);
        rd(3'd7);
        check("frz_status", rd40, 32'h1);
        rd(3'd6);
        check("frz_control", rd40, 32'h2);

        // reset in the cycle after a read kills the response
        address = 3'd3;
        read    = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        read    = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rdv40), 32'd0);
        check("rst_mid_valid64", 32'(rdv64), 32'd0);
        check("rst_mid_rdata", rd40, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rd(3'd4);
        check("post_rst_cnt", rd40, 32'h0);
        rd(3'd3);
        check("post_rst_scratch40", rd40, 32'h5A5A_0000);
        check("post_rst_scratch64", rd64, 32'h0);
        rd(3'd6);
        check("post_rst_freeze", rd40, 32'h0);
        rd(3'd7);
        check("post_rst_status", rd40, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
